// File: rtl/condiciona_botoes.sv
// Button conditioner: 2-flop synchroniser, whole-vector debounce and single-press acceptance FSM.
// A press is accepted once, held one-hot until release, and multi-button/disabled presses are rejected.
module condiciona_botoes #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] botoes_raw,
    input  logic       habilita,
    output logic [6:0] botoes,
    output logic [2:0] codigo,
    output logic       jogada_pulso,
    output logic       multiplo,
    output logic [1:0] db_estado
);
    // state       | meaning
    // LIVRE       | no button held, waiting for a clean press
    // ACEITA      | press accepted, one-clock pulse
    // PRESSIONADO | accepted button still held
    // INVALIDO    | rejected vector, wait for full release
    typedef enum logic [1:0] {
        LIVRE       = 2'd0,
        ACEITA      = 2'd1,
        PRESSIONADO = 2'd2,
        INVALIDO    = 2'd3
    } estado_t;

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [6:0]    meta_q, sync_q;
    logic [6:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    stavel_q, stavel_d;
    logic [6:0]    sel_q, sel_d;
    estado_t       state_q, state_d;
    logic          um;

    function automatic logic [2:0] indice(input logic [6:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 7; i++)
            if (v[i]) r = 3'(i + 1);
        return r;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q   <= '0;
            sync_q   <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            stavel_q <= '0;
        end else begin
            meta_q   <= botoes_raw;
            sync_q   <= meta_q;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stavel_q <= stavel_d;
        end
    end

    // stavel is loaded on the same clock the counter saturates
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stavel_d = stavel_q;
        if (sync_q != cand_q) begin
            cand_d = sync_q;
            cnt_d  = '0;
        end else begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            if (cnt_d == CNT_MAX) stavel_d = cand_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= LIVRE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    assign um = $onehot(stavel_q);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            LIVRE: begin
                if (stavel_q != 7'd0) begin
                    if (um && habilita) begin
                        sel_d   = stavel_q;
                        state_d = ACEITA;
                    end else begin
                        state_d = INVALIDO;
                    end
                end
            end
            ACEITA:      state_d = PRESSIONADO;
            PRESSIONADO: begin
                if (stavel_q == 7'd0)        state_d = LIVRE;
                else if (stavel_q != sel_q)  state_d = INVALIDO;
            end
            INVALIDO: begin
                if (stavel_q == 7'd0) state_d = LIVRE;
            end
            default: state_d = LIVRE;
        endcase
    end

    always_comb begin
        botoes       = 7'd0;
        codigo       = 3'd0;
        jogada_pulso = 1'b0;
        multiplo     = 1'b0;
        db_estado    = state_q;
        case (state_q)
            ACEITA: begin
                jogada_pulso = 1'b1;
                botoes       = sel_q;
                codigo       = indice(sel_q);
            end
            PRESSIONADO: begin
                botoes = sel_q;
                codigo = indice(sel_q);
            end
            INVALIDO: multiplo = 1'b1;
            default: ;
        endcase
    end
endmodule
